// File: rtl/lcd_display_nios2_qsys_0_ociram_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_display_nios2_qsys_0_ociram_arbiter
//
// Shares the single-port OCI debug RAM between the CPU debug-slave port and
// the JTAG debug path. The JTAG path has fixed priority; the CPU is stalled
// through cpu_waitrequest while a JTAG operation is pending or in flight.
//
// JTAG commands arrive as one-cycle strobes (take_action_ocimem_a/_b,
// take_no_action_ocimem_a) and land in a one-deep command register. Reads
// and writes auto-increment MonAReg, and completion raises monitor_ready.
// A strobe that arrives while a command is still pending is dropped and
// raises the sticky monitor_error flag.
//
// Optional feature macro: OCIRAM_CPU_WRPROTECT_EN
//   defined   : CPU writes are accepted but only reach the RAM while
//               debugack=1.
//   undefined : debugack is ignored and every CPU write reaches the RAM.
// ---------------------------------------------------------------------------
module lcd_display_nios2_qsys_0_ociram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,

    // JTAG debug path (debug module, sysclk domain)
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,

    // CPU debug-slave port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_waitrequest,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_readdatavalid,

    // OCI RAM port
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    // Monitor registers returned to the debug TCK logic
    output logic [ADDR_W-1:0] MonAReg,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    // -----------------------------------------------------------------------
    // Types and state
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // arbitrate: pending JTAG op first, then CPU
        ST_JRD  = 2'd1,   // JTAG read data returning from the RAM
        ST_CRD  = 2'd2    // CPU read data returning from the RAM
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } jop_e;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e              state_q,  state_d;
    jop_e                op_q,     op_d;
    logic                valid_q,  valid_d;
    logic [ADDR_W-1:0]   mon_a_q,  mon_a_d;
    logic [DATA_W-1:0]   mon_d_q,  mon_d_d;
    logic                ready_q,  ready_d;
    logic                error_q,  error_d;

    // Handshake between the arbitration FSM and the JTAG command register
    logic                cpu_grant;
    logic                jtag_done;
    logic                jtag_rd_load;
    logic                cpu_wr_allow;

    // JTAG strobe decode
    logic                jtag_strobe;
    logic [ADDR_W-1:0]   jdo_addr;
    logic [DATA_W-1:0]   jdo_data;
    logic                jdo_rd_flag;

    assign jtag_strobe = take_action_ocimem_a | take_action_ocimem_b
                       | take_no_action_ocimem_a;
    assign jdo_addr    = jdo[17+ADDR_W:18];
    assign jdo_data    = jdo[34:3];
    assign jdo_rd_flag = jdo[35];

    // Bits of jdo that carry nothing this block needs, plus debugack when
    // write protection is compiled out.
    logic unused_sigs;
`ifdef OCIRAM_CPU_WRPROTECT_EN
    assign cpu_wr_allow = debugack;
    assign unused_sigs  = ^{jdo[37:36], jdo[2:0]};
`else
    assign cpu_wr_allow = 1'b1;
    assign unused_sigs  = ^{jdo[37:36], jdo[2:0], debugack};
`endif

    // -----------------------------------------------------------------------
    // State and monitor registers; reset aborts any access in flight and
    // drops the pending JTAG command.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_RD;
            valid_q <= 1'b0;
            mon_a_q <= '0;
            mon_d_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            state_q <= state_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            mon_a_q <= mon_a_d;
            mon_d_q <= mon_d_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    // -----------------------------------------------------------------------
    // Arbitration FSM: next state and RAM / CPU-side outputs.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a signal unassigned (latch).
        state_d           = state_q;
        cpu_grant         = 1'b0;
        jtag_done         = 1'b0;
        jtag_rd_load      = 1'b0;
        ram_addr          = '0;
        ram_wren          = 1'b0;
        ram_byteen        = 4'h0;
        ram_wdata         = '0;
        cpu_rdata         = '0;
        cpu_readdatavalid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (valid_q) begin
                    // Pending JTAG command always wins over the CPU.
                    ram_addr = mon_a_q;
                    if (op_q == OP_WR) begin
                        ram_wren   = 1'b1;
                        ram_byteen = 4'hF;
                        ram_wdata  = mon_d_q;
                        jtag_done  = 1'b1;
                    end else begin
                        state_d = ST_JRD;
                    end
                end else if (cpu_req) begin
                    cpu_grant = 1'b1;
                    ram_addr  = cpu_addr;
                    if (cpu_we) begin
                        ram_wren   = cpu_wr_allow;
                        ram_byteen = cpu_be;
                        ram_wdata  = cpu_wdata;
                    end else begin
                        state_d = ST_CRD;
                    end
                end
            end

            ST_JRD: begin
                // Hold the address while the RAM returns the word.
                ram_addr     = mon_a_q;
                jtag_done    = 1'b1;
                jtag_rd_load = 1'b1;
                state_d      = ST_IDLE;
            end

            ST_CRD: begin
                cpu_readdatavalid = 1'b1;
                cpu_rdata         = ram_rdata;
                state_d           = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // JTAG command register, MonAReg/MonDReg and monitor flags.
    // Completion is applied first so a same-cycle MonAReg reload from
    // take_action_ocimem_a overrides the post-access increment.
    // -----------------------------------------------------------------------
    always_comb begin
        op_d    = op_q;
        valid_d = valid_q;
        mon_a_d = mon_a_q;
        mon_d_d = mon_d_q;
        ready_d = ready_q;
        error_d = error_q;

        // Any strobe withdraws the previous "ready" indication.
        if (jtag_strobe) begin
            ready_d = 1'b0;
        end

        // Completion of the pending command. A strobe in the same cycle is
        // necessarily dropped (valid_q=1), so ready still reports the
        // command that just finished.
        if (jtag_done) begin
            valid_d = 1'b0;
            mon_a_d = mon_a_q + ADDR_ONE;
            ready_d = 1'b1;
            if (jtag_rd_load) begin
                mon_d_d = ram_rdata;
            end
        end

        // take_action_ocimem_a reloads the address and clears the error
        // flag even when its command part is about to be dropped.
        if (take_action_ocimem_a) begin
            mon_a_d = jdo_addr;
            error_d = 1'b0;
        end

        if (jtag_strobe && valid_q) begin
            // Overrun: the command register is still occupied.
            error_d = 1'b1;
        end else if (take_action_ocimem_a) begin
            if (jdo_rd_flag) begin
                valid_d = 1'b1;
                op_d    = OP_RD;
            end
        end else if (take_action_ocimem_b) begin
            mon_d_d = jdo_data;
            valid_d = 1'b1;
            op_d    = OP_WR;
        end else if (take_no_action_ocimem_a) begin
            valid_d = 1'b1;
            op_d    = OP_RD;
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign cpu_waitrequest = cpu_req & ~cpu_grant;
    assign MonAReg         = mon_a_q;
    assign MonDReg         = mon_d_q;
    assign monitor_ready   = ready_q;
    assign monitor_error   = error_q;

endmodule

// File: tb/tb_lcd_display_nios2_qsys_0_ociram_arbiter.sv
// ---------------------------------------------------------------------------
// Directed bench for lcd_display_nios2_qsys_0_ociram_arbiter.
// A behavioural 256x32 RAM with one-cycle read latency sits on the RAM port.
// Expected values are hand-computed from the stimulus and the RAM preload
// (mem[i] = 0x5A5A0000 | i, except 0x20 = 0x12345678, 0xFF = 0xCAFEF00D).
// ---------------------------------------------------------------------------
module tb_lcd_display_nios2_qsys_0_ociram_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic              debugack;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [3:0]        cpu_be;
    logic              cpu_waitrequest;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_readdatavalid;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [3:0]        ram_byteen;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] MonAReg;
    logic [DATA_W-1:0] MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic        tb_init;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    lcd_display_nios2_qsys_0_ociram_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .debugack                (debugack),
        .cpu_req                 (cpu_req),
        .cpu_we                  (cpu_we),
        .cpu_addr                (cpu_addr),
        .cpu_wdata               (cpu_wdata),
        .cpu_be                  (cpu_be),
        .cpu_waitrequest         (cpu_waitrequest),
        .cpu_rdata               (cpu_rdata),
        .cpu_readdatavalid       (cpu_readdatavalid),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_byteen              (ram_byteen),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonAReg                 (MonAReg),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    // Behavioural single-port RAM: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 32'h5A5A0000 | 32'(i);
            end
            mem[8'h20] <= 32'h12345678;
            mem[8'hFF] <= 32'hCAFEF00D;
            ram_rdata  <= '0;
        end else begin
            if (ram_wren) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
        logic [37:0] j;
        j        = '0;
        j[25:18] = addr;
        j[35]    = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_d(input logic [31:0] data);
        logic [37:0] j;
        j       = '0;
        j[34:3] = data;
        return j;
    endfunction

    // Safety net in case the DUT or the bench stops advancing.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n                 = 1'b0;
        tb_init                 = 1'b1;
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        debugack                = 1'b0;
        cpu_req                 = 1'b0;
        cpu_we                  = 1'b0;
        cpu_addr                = '0;
        cpu_wdata               = '0;
        cpu_be                  = 4'h0;

        // ---- Reset state ----
        step(); step();
        check("rst_areg",  32'(MonAReg), 32'h0);
        check("rst_dreg",  MonDReg, 32'h0);
        check("rst_ready", 32'(monitor_ready), 32'h0);
        check("rst_error", 32'(monitor_error), 32'h0);
        check("rst_rdv",   32'(cpu_readdatavalid), 32'h0);
        check("rst_wren",  32'(ram_wren), 32'h0);
        tb_init = 1'b0;
        reset_n = 1'b1;
        step();

        // ---- JTAG write 0xDEADBEEF to 0x10, then read it back ----
        jdo = jdo_a(8'h10, 1'b0); take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0; jdo = '0;
        check("t1_areg_load", 32'(MonAReg), 32'h10);
        jdo = jdo_d(32'hDEADBEEF); take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0; jdo = '0;
        #1;
        check("t1_wr_wren",   32'(ram_wren), 32'h1);
        check("t1_wr_addr",   32'(ram_addr), 32'h10);
        check("t1_wr_data",   ram_wdata, 32'hDEADBEEF);
        check("t1_wr_be",     32'(ram_byteen), 32'hF);
        check("t1_wr_notrdy", 32'(monitor_ready), 32'h0);
        step();
        check("t1_wr_ready",  32'(monitor_ready), 32'h1);
        check("t1_wr_ainc",   32'(MonAReg), 32'h11);
        check("t1_ram_10",    mem[8'h10], 32'hDEADBEEF);
        jdo = jdo_a(8'h10, 1'b1); take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0; jdo = '0;
        check("t1_rd_clr_rdy", 32'(monitor_ready), 32'h0);
        check("t1_rd_areg",    32'(MonAReg), 32'h10);
        step();
        check("t1_rd_wait",    32'(monitor_ready), 32'h0);
        step();
        check("t1_rd_ready",   32'(monitor_ready), 32'h1);
        check("t1_rd_dreg",    MonDReg, 32'hDEADBEEF);
        check("t1_rd_ainc",    32'(MonAReg), 32'h11);

        // ---- Wrap: read at 0xFF, address rolls to 0x00 ----
        jdo = jdo_a(8'hFF, 1'b0); take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0; jdo = '0;
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        #1;
        check("wrap_addr", 32'(ram_addr), 32'hFF);
        step(); step();
        check("wrap_dreg",  MonDReg, 32'hCAFEF00D);
        check("wrap_areg",  32'(MonAReg), 32'h00);
        check("wrap_ready", 32'(monitor_ready), 32'h1);

        // ---- Collision: CPU read of 0x20 against a queued JTAG write ----
        jdo = jdo_d(32'h11112222); take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0; jdo = '0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        #1;
        check("col_wait",      32'(cpu_waitrequest), 32'h1);
        check("col_jwr_wren",  32'(ram_wren), 32'h1);
        check("col_jwr_addr",  32'(ram_addr), 32'h00);
        step();
        check("col_grant",     32'(cpu_waitrequest), 32'h0);
        check("col_cpu_addr",  32'(ram_addr), 32'h20);
        check("col_ram_00",    mem[8'h00], 32'h11112222);
        check("col_areg",      32'(MonAReg), 32'h01);
        step();
        cpu_req = 1'b0;
        #1;
        check("col_rdv",       32'(cpu_readdatavalid), 32'h1);
        check("col_rdata",     cpu_rdata, 32'h12345678);
        step();
        check("col_rdv_clr",   32'(cpu_readdatavalid), 32'h0);

        // ---- Overrun: back-to-back take_no_action_ocimem_a ----
        take_no_action_ocimem_a = 1'b1;
        step(); step();
        take_no_action_ocimem_a = 1'b0;
        check("ovr_error",     32'(monitor_error), 32'h1);
        step();
        check("ovr_areg",      32'(MonAReg), 32'h02);
        check("ovr_dreg",      MonDReg, 32'h5A5A0001);
        check("ovr_ready",     32'(monitor_ready), 32'h1);
        step();
        check("ovr_single",    32'(MonAReg), 32'h02);
        check("ovr_sticky",    32'(monitor_error), 32'h1);
        jdo = jdo_a(8'h30, 1'b0); take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0; jdo = '0;
        check("ovr_err_clr",   32'(monitor_error), 32'h0);
        check("ovr_areg_load", 32'(MonAReg), 32'h30);

        // ---- CPU writes: debugack=0 then debugack=1 with partial enables ----
        debugack = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05;
        cpu_wdata = 32'h00000055; cpu_be = 4'hF;
        #1;
        check("cwr_wait", 32'(cpu_waitrequest), 32'h0);
`ifdef OCIRAM_CPU_WRPROTECT_EN
        check("cwr_prot_wren", 32'(ram_wren), 32'h0);
`else
        check("cwr_wren",      32'(ram_wren), 32'h1);
`endif
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
`ifdef OCIRAM_CPU_WRPROTECT_EN
        check("cwr_prot_ram05", mem[8'h05], 32'h5A5A0005);
`else
        check("cwr_ram05",      mem[8'h05], 32'h00000055);
`endif
        debugack = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h06;
        cpu_wdata = 32'hAABBCCDD; cpu_be = 4'b0010;
        #1;
        check("cwr_dbg_wren", 32'(ram_wren), 32'h1);
        check("cwr_dbg_be",   32'(ram_byteen), 32'h2);
        step();
        cpu_req = 1'b0; cpu_we = 1'b0; debugack = 1'b0;
        check("cwr_ram06",    mem[8'h06], 32'h5A5ACC06);

        // ---- Reset while in CRD, with a JTAG read queued alongside ----
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        take_no_action_ocimem_a = 1'b1;
        #1;
        check("rmid_grant", 32'(cpu_waitrequest), 32'h0);
        step();
        cpu_req = 1'b0; take_no_action_ocimem_a = 1'b0;
        #1;
        check("rmid_in_crd", 32'(cpu_readdatavalid), 32'h1);
        reset_n = 1'b0;
        #1;
        check("rmid_rdv",   32'(cpu_readdatavalid), 32'h0);
        check("rmid_areg",  32'(MonAReg), 32'h0);
        check("rmid_dreg",  MonDReg, 32'h0);
        check("rmid_ready", 32'(monitor_ready), 32'h0);
        step();
        reset_n = 1'b1;
        step(); step(); step();
        check("rmid_no_replay_rdy",  32'(monitor_ready), 32'h0);
        check("rmid_no_replay_areg", 32'(MonAReg), 32'h0);
        check("rmid_idle_wren",      32'(ram_wren), 32'h0);
        check("rmid_idle_rdv",       32'(cpu_readdatavalid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
